// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the MIPS pipeline boundary registers.
package pipe_pkg;

    localparam int          TNEW_W_DEF   = 3;
    localparam int          GPR_AW       = 5;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // T_new counts down one stage per boundary; a producer writing $0 never blocks anyone.
    function automatic logic [31:0] tnew_next(input logic [31:0] tnew,
                                              input logic [GPR_AW-1:0] wa);
        if (tnew == 32'd0 || wa == '0)
            return 32'd0;
        else
            return tnew - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for pipeline stall/bubble statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && count != {CNT_W{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, bubble insertion and perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W           = 32,
    parameter int          NUM_DATA         = 2,
    parameter int          TNEW_W           = TNEW_W_DEF,
    parameter logic [31:0] RESET_PC         = RESET_PC_DEF,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int          CNT_W            = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [GPR_AW-1:0]          in_wa,
    input  logic [TNEW_W-1:0]          in_tnew,
    input  logic                       in_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [GPR_AW-1:0]          out_wa,
    output logic [TNEW_W-1:0]          out_tnew,
    output logic                       out_valid,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
);

    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = !flush && !en;
    assign bubble_inc = flush;

    // A bubble keeps its PC so exception handling can still attribute the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pc    <= RESET_PC;
            out_instr <= NOP_INSTR;
            out_data  <= '0;
            out_wa    <= '0;
            out_tnew  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_pc    <= KEEP_PC_ON_FLUSH ? in_pc : RESET_PC;
            out_instr <= NOP_INSTR;
            out_data  <= '0;
            out_wa    <= '0;
            out_tnew  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_data  <= in_data;
            out_wa    <= in_wa;
            out_tnew  <= TNEW_W'(tnew_next(32'(in_tnew), in_wa));
            out_valid <= in_valid;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance plus a 2-bit-counter, reset-PC-on-flush instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, in_valid;
    logic [31:0] in_pc, in_instr;
    logic [63:0] in_data;
    logic [4:0]  in_wa;
    logic [2:0]  in_tnew;

    logic [31:0] a_pc, a_instr, b_pc, b_instr;
    logic [63:0] a_data, b_data;
    logic [4:0]  a_wa, b_wa;
    logic [2:0]  a_tnew, b_tnew;
    logic        a_valid, b_valid;
    logic [15:0] a_stall, a_bubble;
    logic [1:0]  b_stall, b_bubble;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_wa(in_wa),
        .in_tnew(in_tnew), .in_valid(in_valid),
        .out_pc(a_pc), .out_instr(a_instr), .out_data(a_data), .out_wa(a_wa),
        .out_tnew(a_tnew), .out_valid(a_valid),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_wa(in_wa),
        .in_tnew(in_tnew), .in_valid(in_valid),
        .out_pc(b_pc), .out_instr(b_instr), .out_data(b_data), .out_wa(b_wa),
        .out_tnew(b_tnew), .out_valid(b_valid),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [63:0] data,
                         input logic [4:0] wa, input logic [2:0] tnew, input logic valid);
        in_pc    = pc;
        in_instr = instr;
        in_data  = data;
        in_wa    = wa;
        in_tnew  = tnew;
        in_valid = valid;
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [63:0] data, input logic [4:0] wa, input logic [2:0] tnew,
                           input logic valid);
        check({tag, ".pc"},    64'(a_pc),    64'(pc));
        check({tag, ".instr"}, 64'(a_instr), 64'(instr));
        check({tag, ".data"},  a_data,       data);
        check({tag, ".wa"},    64'(a_wa),    64'(wa));
        check({tag, ".tnew"},  64'(a_tnew),  64'(tnew));
        check({tag, ".valid"}, 64'(a_valid), 64'(valid));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0;
        drive(32'h1234_5678, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 3'd7, 1'b1);
        step();
        step();
        check_a("reset", 32'h0000_3000, 32'h0, 64'h0, 5'd0, 3'd0, 1'b0);
        check("reset.stall",  64'(a_stall),  64'd0);
        check("reset.bubble", 64'(a_bubble), 64'd0);
        check("reset.b_pc",   64'(b_pc),     64'h3000);
        check("reset.b_stall", 64'(b_stall), 64'd0);

        reset = 1'b0; en = 1'b1;
        drive(32'h0000_3004, 32'h2108_0001, {32'hAAAA_0001, 32'h5555_0002}, 5'd8, 3'd2, 1'b1);
        step();
        check_a("cap1", 32'h3004, 32'h2108_0001, 64'hAAAA_0001_5555_0002, 5'd8, 3'd1, 1'b1);
        check("cap1.stall", 64'(a_stall), 64'd0);

        in_tnew = 3'd0;
        step();
        check("cap_tnew0", 64'(a_tnew), 64'd0);

        drive(32'h0000_3008, 32'h0000_0000, 64'h1, 5'd0, 3'd3, 1'b1);
        step();
        check("zero_wa.tnew", 64'(a_tnew), 64'd0);
        check("zero_wa.wa",   64'(a_wa),   64'd0);

        drive(32'h0000_300C, 32'h8C09_0004, 64'h0123_4567_89AB_CDEF, 5'd31, 3'd7, 1'b0);
        step();
        check_a("cap_max", 32'h300C, 32'h8C09_0004, 64'h0123_4567_89AB_CDEF, 5'd31, 3'd6, 1'b0);

        drive(32'h0000_3008, 32'h0109_5020, {32'hCAFE_0001, 32'hBEEF_0002}, 5'd9, 3'd3, 1'b1);
        step();
        check_a("hold_base", 32'h3008, 32'h0109_5020, 64'hCAFE_0001_BEEF_0002, 5'd9, 3'd2, 1'b1);

        en = 1'b0;
        drive(32'h0000_4000, 32'hFFFF_0000, 64'h1111_2222_3333_4444, 5'd3, 3'd5, 1'b0);
        step();
        drive(32'h0000_5000, 32'h0F0F_0F0F, 64'h5555_6666_7777_8888, 5'd4, 3'd1, 1'b1);
        step();
        drive(32'h0000_6000, 32'hA5A5_A5A5, 64'h9999_AAAA_BBBB_CCCC, 5'd5, 3'd6, 1'b0);
        step();
        check_a("hold3", 32'h3008, 32'h0109_5020, 64'hCAFE_0001_BEEF_0002, 5'd9, 3'd2, 1'b1);
        check("hold3.stall",   64'(a_stall),  64'd3);
        check("hold3.b_stall", 64'(b_stall),  64'd3);
        check("hold3.bubble",  64'(a_bubble), 64'd0);

        step();
        step();
        step();
        check_a("hold6", 32'h3008, 32'h0109_5020, 64'hCAFE_0001_BEEF_0002, 5'd9, 3'd2, 1'b1);
        check("hold6.stall",   64'(a_stall), 64'd6);
        check("hold6.b_sat",   64'(b_stall), 64'd3);

        flush = 1'b1;
        drive(32'h0000_3010, 32'h2108_0001, 64'hFFFF_0000_FFFF_0000, 5'd7, 3'd2, 1'b1);
        step();
        check_a("flush", 32'h3010, 32'h0, 64'h0, 5'd0, 3'd0, 1'b0);
        check("flush.bubble",   64'(a_bubble), 64'd1);
        check("flush.stall",    64'(a_stall),  64'd6);
        check("flush.b_pc",     64'(b_pc),     64'h3000);
        check("flush.b_instr",  64'(b_instr),  64'h0);
        check("flush.b_bubble", 64'(b_bubble), 64'd1);

        en = 1'b1;
        in_pc = 32'h0000_3014;
        step();
        check("flush_en.pc",     64'(a_pc),     64'h3014);
        check("flush_en.valid",  64'(a_valid),  64'd0);
        check("flush_en.bubble", 64'(a_bubble), 64'd2);
        check("flush_en.stall",  64'(a_stall),  64'd6);

        flush = 1'b0; en = 1'b0;
        step();
        check("stall7", 64'(a_stall), 64'd7);

        reset = 1'b1;
        step();
        check("rst_hold.stall",  64'(a_stall),  64'd0);
        check("rst_hold.bubble", 64'(a_bubble), 64'd0);
        check("rst_hold.pc",     64'(a_pc),     64'h3000);
        check("rst_hold.b_stall", 64'(b_stall), 64'd0);
        check("rst_hold.b_pc",   64'(b_pc),     64'h3000);

        reset = 1'b0; flush = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("bubble4",       64'(a_bubble), 64'd4);
        check("bubble4.b_sat", 64'(b_bubble), 64'd3);
        check("bubble4.stall", 64'(a_stall),  64'd0);

        flush = 1'b0; en = 1'b1;
        drive(32'h0000_3020, 32'h1000_FFFF, 64'h0000_0001_0000_0002, 5'd2, 3'd1, 1'b1);
        step();
        check_a("recap", 32'h3020, 32'h1000_FFFF, 64'h0000_0001_0000_0002, 5'd2, 3'd0, 1'b1);
        check("recap.b_pc",   64'(b_pc),   64'h3020);
        check("recap.b_data", b_data,      64'h0000_0001_0000_0002);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage MIPS CPU. It replaces the per-boundary registers (D/E, E/M, M/W) with one generic block and is instantiated once per boundary. It carries PC, instruction, NUM_DATA data words, the destination register address and T_new, with stall (hold), flush (bubble insertion) and valid tracking. Saturating stall/bubble counters are included for performance debug.

Parameters:
DATA_W, 32, width of each data word
NUM_DATA, 2, number of data words carried (ALU result, mem data, ...); must be >= 1
TNEW_W, 3, width of T_new field
RESET_PC, 32'h0000_3000, PC value after reset
KEEP_PC_ON_FLUSH, 1, 1: bubble keeps in_pc (EPC tracking); 0: bubble loads RESET_PC
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  1: capture inputs; 0: hold
flush  in  1  1: load bubble (overrides en)
in_pc  in  32  PC from previous stage
in_instr  in  32  instruction from previous stage
in_data  in  NUM_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W]
in_wa  in  5  destination GPR address (0 = no write)
in_tnew  in  TNEW_W  producer T_new at previous stage
in_valid  in  1  previous stage holds a real instruction
out_pc  out  32  registered PC
out_instr  out  32  registered instruction
out_data  out  NUM_DATA*DATA_W  registered data words
out_wa  out  5  registered destination address
out_tnew  out  TNEW_W  T_new as seen in this stage
out_valid  out  1  registered valid
stall_cnt  out  CNT_W  cycles with en=0, flush=0
bubble_cnt  out  CNT_W  cycles with flush=1

Behaviour:
- Reset is synchronous and active-high on clk; clock is clk. All outputs are registered, and all updates occur on posedge clk.
- Priority: reset > flush > en > hold.
- Reset: out_pc=RESET_PC. out_instr, out_data, out_wa, out_tnew, out_valid, stall_cnt and bubble_cnt are all 0.
- Flush (independent of en):
  - out_instr=0 (nop), out_data=0, out_wa=0, out_tnew=0, out_valid=0.
  - out_pc = in_pc if KEEP_PC_ON_FLUSH, else RESET_PC.
  - bubble_cnt increments, saturating at all-ones.
- Capture (en=1, flush=0):
  - out_pc, out_instr, out_data, out_wa and out_valid take their inputs.
  - out_tnew = 0 if in_tnew==0 or in_wa==0; otherwise in_tnew-1. There is no underflow.
- Hold (en=0, flush=0):
  - Every data/control output keeps its value, including all data words. No field passes through while stalled.
  - out_tnew is not decremented during hold.
  - stall_cnt increments, saturating at all-ones.
- Latency: 1 cycle from input to output. There is no combinational path from any input to any output.
- Counters never wrap. Reset mid-stall or mid-flush clears everything on the next edge.
- flush=1 with en=0 produces a bubble and counts as a bubble, not a stall.

Decomposition:
- Package pipe_pkg holds: TNEW_W default, RESET_PC, NOP_INSTR=32'h0, the GPR address width (5), and a function tnew_next(tnew, wa) implementing the decrement rule.
- One sub-module, sat_counter (width CNT_W, inc, clear), is instantiated twice.

Test Plan:
- Reset: assert reset for 2 cycles -> out_pc=32'h0000_3000; all other outputs, including both counters, are 0.
- Capture: en=1, in_pc=32'h3004, in_wa=5'd8, in_tnew=2, in_data={32'hAAAA_0001, 32'h5555_0002}, in_valid=1 -> next cycle out_tnew=1 and all fields equal the inputs; repeat with in_tnew=0 -> out_tnew=0.
- Zero destination: in_wa=0, in_tnew=3, en=1 -> out_tnew=0.
- Hold: capture once, then en=0 for 3 cycles while changing every input -> all outputs unchanged and stall_cnt=3.
- Flush: en=0, flush=1, in_pc=32'h3010 -> out_instr=0, out_valid=0, out_pc=32'h3010 (KEEP_PC_ON_FLUSH=1) or 32'h3000 (=0); bubble_cnt=1 and stall_cnt unchanged.
- Saturation: CNT_W=2, hold 6 cycles -> stall_cnt=3; then reset during hold -> stall_cnt=0 and out_pc=32'h3000.
